// File: rtl/ffn_matvec_seq.sv
// Single-layer feed-forward block y = W*x: NUM_OUT MAC lanes share one input neuron per
// cycle, weights stream one column per cycle from an external RAM with one cycle of latency.
module ffn_matvec_seq #(
   parameter  int WIDTH     = 8,
   parameter  int NUM_IN    = 16,
   parameter  int NUM_OUT   = 4,
   parameter  int OUT_WIDTH = 16,
   parameter  int FRAC_BITS = 0,
   localparam int ADDR_W    = (NUM_IN > 2) ? $clog2(NUM_IN) : 1,
   localparam int ACC_W     = 2 * WIDTH + $clog2(NUM_IN)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH*NUM_IN-1:0]      input_neurons,
   input  logic                         relu_en,
   output logic                         weight_rd_en,
   output logic [ADDR_W-1:0]            weight_rd_addr,
   input  logic [WIDTH*NUM_OUT-1:0]     weight_rd_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_WIDTH*NUM_OUT-1:0] output_neurons
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_K     = ADDR_W'(NUM_IN - 1);
   localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(1);
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   state_t state_q, state_d;
   logic [ADDR_W-1:0] cnt_q;
   logic capture, finish;

   logic signed [WIDTH-1:0]     x_q [NUM_IN];
   logic                        relu_q;
   logic                        rd_valid_q;
   logic [ADDR_W-1:0]           rd_addr_q;
   logic signed [2*WIDTH-1:0]   prod_q [NUM_OUT];
   logic                        prod_valid_q;
   logic signed [ACC_W-1:0]     acc_q [NUM_OUT];
   logic [OUT_WIDTH*NUM_OUT-1:0] out_q;

   logic signed [2*WIDTH-1:0]   x_ext;
   logic signed [2*WIDTH-1:0]   w_ext [NUM_OUT];
   logic signed [2*WIDTH-1:0]   prod_d [NUM_OUT];
   logic signed [ACC_W-1:0]     acc_d [NUM_OUT];
   logic signed [ACC_W-1:0]     shifted [NUM_OUT];
   logic [OUT_WIDTH-1:0]        out_d [NUM_OUT];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d        = state_q;
      in_ready       = 1'b0;
      weight_rd_en   = 1'b0;
      weight_rd_addr = '0;
      out_valid      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            weight_rd_en   = 1'b1;
            weight_rd_addr = cnt_q;
            if (cnt_q == LAST_K) state_d = DRAIN;
         end
         DRAIN: if (cnt_q == DRAIN_LAST) state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign capture        = (state_q == IDLE) && in_valid;
   assign finish         = (state_q == DRAIN) && (state_d == DONE);
   assign output_neurons = out_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            cnt_q <= '0;
         else if (state_q == RUN || state_q == DRAIN)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   always_comb begin
      x_ext = {{WIDTH{x_q[rd_addr_q][WIDTH-1]}}, x_q[rd_addr_q]};
      for (int j = 0; j < NUM_OUT; j++) begin
         w_ext[j]   = {{WIDTH{weight_rd_data[WIDTH*j+WIDTH-1]}}, weight_rd_data[WIDTH*j +: WIDTH]};
         prod_d[j]  = x_ext * w_ext[j];
         acc_d[j]   = prod_valid_q ? acc_q[j] + ACC_W'(prod_q[j]) : acc_q[j];
         shifted[j] = acc_d[j] >>> FRAC_BITS;
         if (relu_q && shifted[j][ACC_W-1]) shifted[j] = '0;
         out_d[j]   = shifted[j][OUT_WIDTH-1:0];
         if (shifted[j] > SAT_MAX)      out_d[j] = SAT_MAX[OUT_WIDTH-1:0];
         else if (shifted[j] < SAT_MIN) out_d[j] = SAT_MIN[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         relu_q       <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_addr_q    <= '0;
         prod_valid_q <= 1'b0;
         out_q        <= '0;
         for (int j = 0; j < NUM_OUT; j++) acc_q[j] <= '0;
      end else begin
         rd_valid_q   <= weight_rd_en;
         rd_addr_q    <= weight_rd_addr;
         prod_valid_q <= rd_valid_q;
         if (capture) relu_q <= relu_en;
         for (int j = 0; j < NUM_OUT; j++) begin
            acc_q[j] <= capture ? '0 : acc_d[j];
            if (finish) out_q[OUT_WIDTH*j +: OUT_WIDTH] <= out_d[j];
         end
      end
   end

   // NOTE: operand and product storage is not reset; its valid flags are, which is all control needs.
   always_ff @(posedge clock) begin
      if (capture)
         for (int i = 0; i < NUM_IN; i++) x_q[i] <= input_neurons[WIDTH*i +: WIDTH];
      if (rd_valid_q)
         for (int j = 0; j < NUM_OUT; j++) prod_q[j] <= prod_d[j];
   end

endmodule

// File: tb/tb_ffn_matvec_seq.sv
// Bench for ffn_matvec_seq: two instances (FRAC_BITS 0 and 4) share one stimulus stream and
// are compared against an arithmetic reference model cycle by cycle.
module tb_ffn_matvec_seq;
   localparam int W  = 8;
   localparam int NI = 4;
   localparam int NO = 2;
   localparam int OW = 16;
   localparam int AW = 2;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic            in_valid, relu_en, out_ready;
   logic [W*NI-1:0] input_neurons;
   logic            in_ready0, in_ready1, rd_en0, rd_en1, ov0, ov1;
   logic [AW-1:0]   addr0, addr1;
   logic [W*NO-1:0] wdata0, wdata1;
   logic [OW*NO-1:0] out0, out1;

   ffn_matvec_seq #(.WIDTH(W), .NUM_IN(NI), .NUM_OUT(NO), .OUT_WIDTH(OW), .FRAC_BITS(0)) dut0 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
      .input_neurons(input_neurons), .relu_en(relu_en), .weight_rd_en(rd_en0),
      .weight_rd_addr(addr0), .weight_rd_data(wdata0), .out_valid(ov0),
      .out_ready(out_ready), .output_neurons(out0));

   ffn_matvec_seq #(.WIDTH(W), .NUM_IN(NI), .NUM_OUT(NO), .OUT_WIDTH(OW), .FRAC_BITS(4)) dut1 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .input_neurons(input_neurons), .relu_en(relu_en), .weight_rd_en(rd_en1),
      .weight_rd_addr(addr1), .weight_rd_data(wdata1), .out_valid(ov1),
      .out_ready(out_ready), .output_neurons(out1));

   logic signed [W-1:0] x_cur [NI];
   logic signed [W-1:0] w_cur [NI][NO];
   logic                relu_cur;
   int                  got0 [NO];
   int                  got1 [NO];
   int                  n_checks = 0;
   int                  n_fail = 0;

   // Weight RAM: registered read port, one cycle of latency.
   always @(posedge clock) begin
      for (int j = 0; j < NO; j++) begin
         if (rd_en0) wdata0[W*j +: W] <= w_cur[addr0][j];
         if (rd_en1) wdata1[W*j +: W] <= w_cur[addr1][j];
      end
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model(input int j, input int frac, input logic rl);
      longint acc = 0;
      longint s;
      for (int k = 0; k < NI; k++) acc += longint'(x_cur[k]) * longint'(w_cur[k][j]);
      s = acc >>> frac;
      if (rl && s < 0) s = 0;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      return int'(s);
   endfunction

   task automatic load(input int x0, input int x1, input int x2, input int x3,
                       input int wv, input logic rl);
      x_cur[0] = W'(x0); x_cur[1] = W'(x1); x_cur[2] = W'(x2); x_cur[3] = W'(x3);
      for (int k = 0; k < NI; k++)
         for (int j = 0; j < NO; j++) w_cur[k][j] = W'(wv);
      relu_cur = rl;
   endtask

   task automatic present();
      @(negedge clock);
      for (int i = 0; i < NI; i++) input_neurons[W*i +: W] = x_cur[i];
      relu_en  = relu_cur;
      in_valid = 1'b1;
   endtask

   // Handshake in cycle A, then follow A+1 .. one cycle past the output handshake.
   task automatic run_vec(input int stall);
      int exp0 [NO];
      int exp1 [NO];
      int d;
      for (int j = 0; j < NO; j++) begin
         exp0[j] = model(j, 0, relu_cur);
         exp1[j] = model(j, 4, relu_cur);
      end
      present();
      out_ready = 1'b0;
      check("in_ready_idle0", in_ready0, 1);
      check("in_ready_idle1", in_ready1, 1);
      for (int n = 1; n <= NI + 4 + stall; n++) begin
         @(negedge clock);
         input_neurons = $urandom;
         relu_en       = 1'($urandom_range(0, 1));
         d = n - (NI + 3);
         check("rd_en0", rd_en0, n <= NI);
         check("rd_en1", rd_en1, n <= NI);
         if (n <= NI) begin
            check("rd_addr0", addr0, n - 1);
            check("rd_addr1", addr1, n - 1);
         end
         check("out_valid0", ov0, d >= 0 && d <= stall);
         check("out_valid1", ov1, d >= 0 && d <= stall);
         check("in_ready0", in_ready0, d > stall);
         check("in_ready1", in_ready1, d > stall);
         if (d >= 0 && d <= stall) begin
            for (int j = 0; j < NO; j++) begin
               check($sformatf("out0[%0d]", j), $signed(out0[OW*j +: OW]), exp0[j]);
               check($sformatf("out1[%0d]", j), $signed(out1[OW*j +: OW]), exp1[j]);
               if (d == 0) begin
                  got0[j] = int'($signed(out0[OW*j +: OW]));
                  got1[j] = int'($signed(out1[OW*j +: OW]));
               end
            end
         end
         if (d > stall) in_valid = 1'b0;
         else           out_ready = (d >= stall);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; relu_en = 1'b0; input_neurons = '0;
      relu_cur = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_in_ready", in_ready0, 1);
      check("rst_rd_en", rd_en0, 0);
      check("rst_rd_addr", addr0, 0);
      check("rst_out_valid", ov0, 0);
      check("rst_out0", out0, 0);
      check("rst_out1", out1, 0);
      reset = 1'b0;

      // Basic dot product with exact output timing.
      load(1, 2, 3, 4, 1, 1'b0);
      run_vec(0);
      check("case1_y0", got0[0], 10);
      check("case1_y1", got0[1], 10);

      // Saturation at both rails.
      load(127, 127, 127, 127, 127, 1'b0);
      run_vec(0);
      check("sat_pos", got0[0], 32767);
      load(-128, -128, -128, -128, 127, 1'b0);
      run_vec(1);
      check("sat_neg", got0[1], -32768);

      // ReLU on and off.
      load(-1, -2, -3, -4, 1, 1'b0);
      run_vec(0);
      check("norelu", got0[0], -10);
      load(-1, -2, -3, -4, 1, 1'b1);
      run_vec(0);
      check("relu", got0[0], 0);

      // Floor shift on the FRAC_BITS=4 instance.
      load(-17, 0, 0, 0, 1, 1'b0);
      run_vec(0);
      check("floor_neg", got1[0], -2);
      load(17, 0, 0, 0, 1, 1'b0);
      run_vec(0);
      check("floor_pos", got1[0], 1);

      // Downstream stall for 5 cycles with a second vector pending.
      load(1, 2, 3, 4, 1, 1'b0);
      run_vec(5);

      // Reset in the middle of RUN aborts the vector.
      load(5, 6, 7, 8, 3, 1'b0);
      present();
      @(negedge clock); in_valid = 1'b0;
      @(negedge clock);
      @(negedge clock); reset = 1'b1;
      @(negedge clock);
      check("abort_out_valid", ov0, 0);
      check("abort_out", out0, 0);
      check("abort_rd_en", rd_en0, 0);
      check("abort_in_ready", in_ready0, 1);
      reset = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clock);
         check("abort_quiet_ov", ov0, 0);
         check("abort_quiet_rd", rd_en1, 0);
      end
      load(1, 2, 3, 4, 1, 1'b0);
      run_vec(0);
      check("post_reset_y0", got0[0], 10);

      // Randomized vectors against the model.
      for (int t = 0; t < 12; t++) begin
         for (int k = 0; k < NI; k++) begin
            x_cur[k] = W'($urandom_range(0, 255));
            for (int j = 0; j < NO; j++) w_cur[k][j] = W'($urandom_range(0, 255));
         end
         relu_cur = 1'($urandom_range(0, 1));
         run_vec(int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end
endmodule
